// File: rtl/uart_pkg.sv
// Shared UART configuration: divisor widths, oversampling ratio, reset-time
// divisor and the packed {integer, fraction} divisor type.
package uart_pkg;

    localparam int DIV_W       = 16;  // system clocks per oversample tick (integer part)
    localparam int FRAC_W      = 4;   // fractional part, in 1/2^FRAC_W clock units
    localparam int OVERSAMPLE  = 16;  // oversample ticks per bit; even, >= 4
    localparam int DEFAULT_INT = 27;  // 50 MHz / 115200 / 16 = 27.13
    localparam int DEFAULT_FRC = 2;   // 2/16 = 0.125

    typedef struct packed {
        logic [DIV_W-1:0]  int_part;
        logic [FRAC_W-1:0] frac_part;
    } divisor_t;

    localparam divisor_t DEFAULT_DIV = '{
        int_part:  DIV_W'(DEFAULT_INT),
        frac_part: FRAC_W'(DEFAULT_FRC)
    };

    // An integer divisor of zero would mean a zero-length period; run it as 1.
    function automatic logic [DIV_W-1:0] eff_int(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator for the baud generator. The carry out of
// acc + frac stretches the current oversample period by one clock; the
// accumulator only moves when the top level signals a period boundary.
module baud_frac_acc
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              sync_clr,
    input  logic              advance,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    // Accumulate the fraction once per period; resync restarts from zero phase.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc <= '0;
        end else if (sync_clr) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: single-cycle oversample, mid-bit and
// bit pulses from an integer+fractional divisor. A divisor loaded while
// running is held in a shadow register and swapped in at the next
// oversample boundary so a period is never cut short or stretched mid-way.
module baud_tick_gen
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              load_pend
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
    localparam logic [DIV_W:0]  CNT_ONE = (DIV_W + 1)'(1);

    // One extra bit so the longest period (2^DIV_W - 1 plus a carry) fits.
    logic [DIV_W:0]  cnt;
    logic [OS_W-1:0] os_cnt;
    divisor_t        active;
    divisor_t        shadow;
    divisor_t        new_div;
    logic            carry;
    logic [DIV_W:0]  period;
    logic            wrap;
    logic            tick_now;

    assign new_div  = '{int_part: div_int, frac_part: div_frac};
    assign period   = {1'b0, eff_int(active.int_part)} + {{DIV_W{1'b0}}, carry};
    assign wrap     = (cnt == period - CNT_ONE);
    // resync beats a coinciding wrap: that boundary produces no tick.
    assign tick_now = en & wrap & ~resync;

    baud_frac_acc u_frac_acc (
        .clk      (clk),
        .clr      (clr),
        .sync_clr (resync),
        .advance  (tick_now),
        .frac     (active.frac_part),
        .carry    (carry)
    );

    // Period counter and oversample position within the bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (resync) begin
            cnt    <= '0;
            os_cnt <= '0;
        end else if (en) begin
            if (wrap) begin
                cnt    <= '0;
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // Registered tick pulses, decoded from the pre-wrap oversample position.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= tick_now;
            mid_tick <= tick_now && (os_cnt == OS_MID);
            bit_tick <= tick_now && (os_cnt == OS_LAST);
        end
    end

    // Shadow/active divisor handover: immediate when stopped or restarting,
    // otherwise deferred to the next oversample boundary.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            active    <= DEFAULT_DIV;
            shadow    <= DEFAULT_DIV;
            load_pend <= 1'b0;
        end else begin
            if (div_load) begin
                shadow <= new_div;
            end
            if (div_load && (resync || !en)) begin
                active    <= new_div;
                load_pend <= 1'b0;
            end else if (div_load) begin
                load_pend <= 1'b1;
            end else if (load_pend && (resync || tick_now)) begin
                active    <= shadow;
                load_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen. Stimulus pushes the hand-derived edge number and
// kind of every expected tick into exp_q; a negedge monitor pops one entry
// for each cycle where any tick output is high and compares.
module tb_baud_tick_gen;
    import uart_pkg::*;

    logic              clk      = 1'b0;
    logic              clr      = 1'b1;
    logic              en       = 1'b0;
    logic [DIV_W-1:0]  div_int  = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_load = 1'b0;
    logic              resync   = 1'b0;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic              load_pend;

    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_act;
    logic [31:0] mon_exp;

    baud_tick_gen dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .div_load  (div_load),
        .resync    (resync),
        .os_tick   (os_tick),
        .mid_tick  (mid_tick),
        .bit_tick  (bit_tick),
        .load_pend (load_pend)
    );

    // Clock and edge counter: after posedge k, cyc == k.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with a tick must match the head of the queue.
    always @(negedge clk) begin
        if (os_tick || mid_tick || bit_tick) begin
            mon_act = {os_tick, mid_tick, bit_tick, 29'(cyc)};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tick_unexpected: got os/mid/bit=%b at edge %0d, none expected",
                         mon_act[31:29], cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tick_event: got os/mid/bit=%b at edge %0d, want %b at edge %0d",
                             mon_act[31:29], mon_act[28:0], mon_exp[31:29], mon_exp[28:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, want finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int c, input logic o, input logic m, input logic b);
        exp_q.push_back({o, m, b, 29'(c)});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d expected ticks unseen (next at edge %0d), want 0",
                     name, exp_q.size(), exp_q[0][28:0]);
            exp_q.delete();
        end
    endtask

    // Returns the number of the edge that will capture inputs driven now.
    task automatic next_edge(output int e);
        @(posedge clk);
        #1;
        e = cyc + 1;
    endtask

    // Returns just after edge e (immediately if it has already passed).
    task automatic after_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load a divisor together with resync; the strobe edge becomes phase zero.
    task automatic load_resync(input int di, input int df, output int n);
        next_edge(n);
        div_int  = DIV_W'(di);
        div_frac = FRAC_W'(df);
        div_load = 1'b1;
        resync   = 1'b1;
        en       = 1'b1;
        after_edge(n);
        div_load = 1'b0;
        resync   = 1'b0;
    endtask

    initial begin
        int n;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_os_tick", 32'(os_tick), 0);
        chk("reset_mid_tick", 32'(mid_tick), 0);
        chk("reset_bit_tick", 32'(bit_tick), 0);
        chk("reset_load_pend", 32'(load_pend), 0);

        // Default divisor 27 + 2/16: seven periods of 27 then one of 28
        next_edge(n);
        clr = 1'b0;
        en  = 1'b1;
        t = n - 1;
        for (int j = 1; j <= 32; j++) begin
            t += (j % 8 == 0) ? 28 : 27;
            push_ev(t, 1'b1, j % 16 == 8, j % 16 == 0);
        end
        after_edge(t);
        en = 1'b0;
        after_edge(t + 1);
        check_empty("default_div_ticks");

        // Integer divisor 4: os every 4, mid on #8, bit on #16 (64 clocks apart)
        load_resync(4, 0, n);
        chk("load_with_resync_pend", 32'(load_pend), 0);
        for (int j = 1; j <= 32; j++) push_ev(n + 4 * j, 1'b1, j % 16 == 8, j % 16 == 0);
        after_edge(n + 128);
        en = 1'b0;
        after_edge(n + 129);
        check_empty("int4_ticks");

        // Fractional 4 + 8/16: periods 4,5,4,5...; 16 ticks span 72 clocks
        load_resync(4, 8, n);
        t = n;
        for (int j = 1; j <= 16; j++) begin
            t += (j % 2 == 1) ? 4 : 5;
            push_ev(t, 1'b1, j == 8, j == 16);
        end
        chk("frac_span_72", 32'(t - n), 72);
        after_edge(t);
        en = 1'b0;
        after_edge(t + 1);
        check_empty("frac_ticks");

        // Resync on the edge where a wrap is due: no tick there, restart phase
        load_resync(4, 0, n);
        push_ev(n + 4, 1'b1, 1'b0, 1'b0);
        push_ev(n + 8, 1'b1, 1'b0, 1'b0);
        after_edge(n + 11);
        resync = 1'b1;
        after_edge(n + 12);
        resync = 1'b0;
        n = n + 12;
        for (int j = 1; j <= 8; j++) push_ev(n + 4 * j, 1'b1, j == 8, 1'b0);
        after_edge(n + 32);
        en = 1'b0;
        after_edge(n + 33);
        check_empty("resync_ticks");

        // Deferred load: int 10, load 3 two clocks after a tick
        load_resync(10, 0, n);
        push_ev(n + 10, 1'b1, 1'b0, 1'b0);
        push_ev(n + 20, 1'b1, 1'b0, 1'b0);
        push_ev(n + 23, 1'b1, 1'b0, 1'b0);
        push_ev(n + 26, 1'b1, 1'b0, 1'b0);
        after_edge(n + 11);
        chk("pend_before_load", 32'(load_pend), 0);
        div_int  = DIV_W'(3);
        div_load = 1'b1;
        after_edge(n + 12);
        div_load = 1'b0;
        for (int k = n + 12; k <= n + 20; k++) begin
            after_edge(k);
            chk($sformatf("pend_deferred_e%0d", k - n), 32'(load_pend), (k < n + 20) ? 1 : 0);
        end
        after_edge(n + 26);
        en = 1'b0;
        after_edge(n + 27);
        check_empty("deferred_load_ticks");

        // Load while stopped applies at once; then en low 5 clocks mid-period
        next_edge(n);
        resync = 1'b1;
        after_edge(n);
        resync   = 1'b0;
        div_int  = DIV_W'(10);
        div_load = 1'b1;
        after_edge(n + 1);
        div_load = 1'b0;
        chk("pend_load_stopped", 32'(load_pend), 0);
        en = 1'b1;
        push_ev(n + 11, 1'b1, 1'b0, 1'b0);
        push_ev(n + 21, 1'b1, 1'b0, 1'b0);
        push_ev(n + 36, 1'b1, 1'b0, 1'b0);
        push_ev(n + 46, 1'b1, 1'b0, 1'b0);
        after_edge(n + 23);
        en = 1'b0;
        after_edge(n + 28);
        en = 1'b1;
        after_edge(n + 46);
        en = 1'b0;
        after_edge(n + 47);
        check_empty("stopped_load_pause_ticks");

        // int 0 runs as period 1: os_tick high every cycle; then async clear
        load_resync(0, 0, n);
        for (int j = 1; j <= 20; j++) push_ev(n + j, 1'b1, j == 8, j == 16);
        after_edge(n + 20);
        #6;
        clr = 1'b1;
        #1;
        chk("clr_async_os_tick", 32'(os_tick), 0);
        chk("clr_async_mid_tick", 32'(mid_tick), 0);
        chk("clr_async_bit_tick", 32'(bit_tick), 0);
        chk("clr_async_load_pend", 32'(load_pend), 0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_empty("period1_ticks");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
